// File: rtl/ndn_fib_lookup_pkg.sv
// ndn_fib_pkg: shared types and constants for the NDN FIB lookup engine.
//   - table geometry and name-length limits
//   - fib_entry_t : one FIB table entry {valid, tag, parent}
//   - slot_t      : one pipeline slot {valid, start, idx, word}
//   - fib_index() : table index hash for a component at a given stage
package ndn_fib_pkg;

    localparam int WORD_SIZE         = 32;
    localparam int TREE_HEIGHT       = 5;
    localparam int POINTER_SIZE      = 6;
    localparam int MAX_NAME_LENGTH   = 8;
    localparam int STRIDE_INDEX_SIZE = 3;

    localparam int TABLE_DEPTH  = 1 << POINTER_SIZE;
    localparam int NUM_CHANNELS = 2;

    typedef logic [WORD_SIZE-1:0]         word_t;
    typedef logic [POINTER_SIZE-1:0]      ptr_t;
    typedef logic [STRIDE_INDEX_SIZE-1:0] sidx_t;

    // Highest component position; later components stay at this index.
    localparam sidx_t IDX_MAX = sidx_t'(MAX_NAME_LENGTH - 1);

    typedef struct packed {
        logic  valid;
        word_t tag;
        ptr_t  parent;
    } fib_entry_t;

    typedef struct packed {
        logic  valid;
        logic  start;
        sidx_t idx;
        word_t word;
    } slot_t;

    // Entry address for a component: low word bits folded with the parent's
    // pointer so that the same component under different parents spreads out.
    function automatic ptr_t fib_index(input word_t word, input ptr_t ptr_prev);
        return word[POINTER_SIZE-1:0] ^ ptr_prev;
    endfunction

endpackage

// File: rtl/ndn_fib_lookup_if.sv
// ndn_fib_if: bundle of the lookup engine's component streams, FIB write
// port and per-stage match outputs.
//   master : name parser / table loader / decision logic side
//   slave  : ndn_fib_lookup side
interface ndn_fib_if;
    import ndn_fib_pkg::*;

    // Component streams, one per channel.
    word_t      name_component_1;
    word_t      name_component_2;
    logic       comp_valid_1;
    logic       comp_valid_2;
    logic       name_start_1;
    logic       name_start_2;

    // Single FIB write port shared by both channels.
    logic       tbl_we;
    logic [2:0] tbl_stage;
    ptr_t       tbl_addr;
    logic       tbl_valid;
    word_t      tbl_tag;
    ptr_t       tbl_parent;

    // Per-stage match bits, channel 1 then channel 2.
    logic       dummy_output_0_1, dummy_output_1_1, dummy_output_2_1;
    logic       dummy_output_3_1, dummy_output_4_1;
    logic       dummy_output_0_2, dummy_output_1_2, dummy_output_2_2;
    logic       dummy_output_3_2, dummy_output_4_2;

    modport master (
        output name_component_1, name_component_2,
        output comp_valid_1, comp_valid_2, name_start_1, name_start_2,
        output tbl_we, tbl_stage, tbl_addr, tbl_valid, tbl_tag, tbl_parent,
        input  dummy_output_0_1, dummy_output_1_1, dummy_output_2_1,
        input  dummy_output_3_1, dummy_output_4_1,
        input  dummy_output_0_2, dummy_output_1_2, dummy_output_2_2,
        input  dummy_output_3_2, dummy_output_4_2
    );

    modport slave (
        input  name_component_1, name_component_2,
        input  comp_valid_1, comp_valid_2, name_start_1, name_start_2,
        input  tbl_we, tbl_stage, tbl_addr, tbl_valid, tbl_tag, tbl_parent,
        output dummy_output_0_1, dummy_output_1_1, dummy_output_2_1,
        output dummy_output_3_1, dummy_output_4_1,
        output dummy_output_0_2, dummy_output_1_2, dummy_output_2_2,
        output dummy_output_3_2, dummy_output_4_2
    );

endinterface

// File: rtl/ndn_fib_lookup_stage.sv
// fib_stage: one lookup level of one channel.
// Computes the table address for the component sitting in its pipeline slot,
// compares the entry read back by the top level and keeps the stage context
// {alive, ptr} that the next level chains from. The alive bit is also the
// registered match output for this prefix depth.
//   clk_in, rst_in : clock, synchronous active-high reset
//   i_slot         : pipeline slot currently at this stage
//   i_prev_alive   : alive bit of stage STAGE-1 (ignored for stage 0)
//   i_prev_ptr     : pointer of stage STAGE-1 (ignored for stage 0)
//   o_rd_addr      : table address to read for this stage
//   i_rd_entry     : table entry at o_rd_addr
//   o_alive        : prefix 0..STAGE matched (registered)
//   o_ptr          : table address of that match (registered)
module fib_stage
    import ndn_fib_pkg::*;
#(
    parameter int STAGE = 0
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  slot_t      i_slot,
    input  logic       i_prev_alive,
    input  ptr_t       i_prev_ptr,
    output ptr_t       o_rd_addr,
    input  fib_entry_t i_rd_entry,
    output logic       o_alive,
    output ptr_t       o_ptr
);

    logic r_alive;
    ptr_t r_ptr;

    logic w_prev_alive;
    ptr_t w_prev_ptr;
    ptr_t w_addr;
    logic w_eval;
    logic w_parent_ok;
    logic w_match;
    logic w_clear;

    // The root level has no parent: it is always reachable from pointer 0.
    assign w_prev_alive = (STAGE == 0) ? 1'b1 : i_prev_alive;
    assign w_prev_ptr   = (STAGE == 0) ? '0   : i_prev_ptr;

    assign w_addr      = fib_index(i_slot.word, w_prev_ptr);
    assign w_eval      = i_slot.valid && (i_slot.idx == sidx_t'(STAGE));
    assign w_parent_ok = (STAGE == 0) || (i_rd_entry.parent == w_prev_ptr);
    assign w_match     = w_prev_alive && i_rd_entry.valid &&
                         (i_rd_entry.tag == i_slot.word) && w_parent_ok;
    // A new name sweeping past a deeper level wipes the previous name's result.
    assign w_clear     = i_slot.valid && i_slot.start && (STAGE != 0);

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples its inputs as they were before the clock edge.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_alive <= 1'b0;
            r_ptr   <= '0;
        end else if (w_eval) begin
            r_alive <= w_match;
            r_ptr   <= w_addr;
        end else if (w_clear) begin
            r_alive <= 1'b0;
        end
    end

    assign o_rd_addr = w_addr;
    assign o_alive   = r_alive;
    assign o_ptr     = r_ptr;

endmodule

// File: rtl/ndn_fib_lookup.sv
// ndn_fib_lookup: two-channel pipelined NDN FIB longest-prefix lookup.
// Each channel takes a name as a stream of component words; component k is
// checked at stage k against that stage's table, chained through the parent
// pointer left by stage k-1. Both channels read the same per-stage tables;
// one write port updates them.
//   clk_in : clock, all logic on the rising edge
//   rst_in : synchronous active-high reset
//   bus    : component streams, table write port and match outputs
module ndn_fib_lookup
    import ndn_fib_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_in,
    ndn_fib_if.slave   bus
);

    // ------------------------------------------------------------------
    // Channel inputs as arrays so both channels share one description.
    // ------------------------------------------------------------------
    word_t w_word  [NUM_CHANNELS];
    logic  w_valid [NUM_CHANNELS];
    logic  w_start [NUM_CHANNELS];

    assign w_word[0]  = bus.name_component_1;
    assign w_word[1]  = bus.name_component_2;
    assign w_valid[0] = bus.comp_valid_1;
    assign w_valid[1] = bus.comp_valid_2;
    assign w_start[0] = bus.name_start_1;
    assign w_start[1] = bus.name_start_2;

    // ------------------------------------------------------------------
    // Stride counter: position of each incoming component in its name.
    // r_have marks that a component has been seen since reset, so a stream
    // that begins without name_start still starts at position 0.
    // ------------------------------------------------------------------
    logic  r_have     [NUM_CHANNELS];
    sidx_t r_last_idx [NUM_CHANNELS];
    sidx_t w_idx      [NUM_CHANNELS];

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            w_idx[ch] = '0;
            if (w_start[ch] || !r_have[ch]) begin
                w_idx[ch] = '0;
            end else if (r_last_idx[ch] == IDX_MAX) begin
                w_idx[ch] = IDX_MAX;
            end else begin
                w_idx[ch] = r_last_idx[ch] + sidx_t'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Pipeline: slot k holds the component that is evaluated at stage k.
    // ------------------------------------------------------------------
    slot_t r_slot [NUM_CHANNELS][TREE_HEIGHT];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                r_have[ch]     <= 1'b0;
                r_last_idx[ch] <= '0;
                for (int k = 0; k < TREE_HEIGHT; k++) begin
                    r_slot[ch][k] <= '0;
                end
            end
        end else begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                r_slot[ch][0] <= '{valid: w_valid[ch],
                                   start: w_valid[ch] && w_start[ch],
                                   idx:   w_idx[ch],
                                   word:  w_word[ch]};
                for (int k = 1; k < TREE_HEIGHT; k++) begin
                    r_slot[ch][k] <= r_slot[ch][k-1];
                end
                if (w_valid[ch]) begin
                    r_have[ch]     <= 1'b1;
                    r_last_idx[ch] <= w_idx[ch];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // FIB tables, one per stage. Only the valid bits are reset.
    // ------------------------------------------------------------------
    logic [TABLE_DEPTH-1:0] r_tbl_valid  [TREE_HEIGHT];
    word_t                  r_tbl_tag    [TREE_HEIGHT][TABLE_DEPTH];
    ptr_t                   r_tbl_parent [TREE_HEIGHT][TABLE_DEPTH];

    logic w_tbl_write;

    // Writes aimed at a stage that does not exist are dropped.
    assign w_tbl_write = bus.tbl_we && (bus.tbl_stage < 3'(TREE_HEIGHT));

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int k = 0; k < TREE_HEIGHT; k++) begin
                r_tbl_valid[k] <= '0;
            end
        end else if (w_tbl_write) begin
            r_tbl_valid[bus.tbl_stage][bus.tbl_addr] <= bus.tbl_valid;
        end
    end

    // NOTE: tag/parent storage is deliberately left out of reset; an entry is
    // only ever consulted through its valid bit, so clearing the payload would
    // add reset fan-out to a RAM-like array for no functional gain.
    always_ff @(posedge clk_in) begin
        if (w_tbl_write) begin
            r_tbl_tag[bus.tbl_stage][bus.tbl_addr]    <= bus.tbl_tag;
            r_tbl_parent[bus.tbl_stage][bus.tbl_addr] <= bus.tbl_parent;
        end
    end

    // ------------------------------------------------------------------
    // Stage array: TREE_HEIGHT levels per channel, reading tables
    // combinationally (a same-cycle write is seen only after the edge).
    // ------------------------------------------------------------------
    ptr_t       w_rd_addr  [NUM_CHANNELS][TREE_HEIGHT];
    fib_entry_t w_rd_entry [NUM_CHANNELS][TREE_HEIGHT];
    logic       w_alive    [NUM_CHANNELS][TREE_HEIGHT];
    ptr_t       w_ptr      [NUM_CHANNELS][TREE_HEIGHT];

    for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_ch
        for (genvar k = 0; k < TREE_HEIGHT; k++) begin : g_stage
            // Stage 0 ignores its chain inputs; point it at itself.
            localparam int PREV = (k == 0) ? 0 : k - 1;

            assign w_rd_entry[ch][k] = '{
                valid:  r_tbl_valid[k][w_rd_addr[ch][k]],
                tag:    r_tbl_tag[k][w_rd_addr[ch][k]],
                parent: r_tbl_parent[k][w_rd_addr[ch][k]]
            };

            fib_stage #(
                .STAGE (k)
            ) u_stage (
                .clk_in       (clk_in),
                .rst_in       (rst_in),
                .i_slot       (r_slot[ch][k]),
                .i_prev_alive (w_alive[ch][PREV]),
                .i_prev_ptr   (w_ptr[ch][PREV]),
                .o_rd_addr    (w_rd_addr[ch][k]),
                .i_rd_entry   (w_rd_entry[ch][k]),
                .o_alive      (w_alive[ch][k]),
                .o_ptr        (w_ptr[ch][k])
            );
        end
    end

    // ------------------------------------------------------------------
    // Match outputs: the stage alive bits are already registered.
    // ------------------------------------------------------------------
    assign bus.dummy_output_0_1 = w_alive[0][0];
    assign bus.dummy_output_1_1 = w_alive[0][1];
    assign bus.dummy_output_2_1 = w_alive[0][2];
    assign bus.dummy_output_3_1 = w_alive[0][3];
    assign bus.dummy_output_4_1 = w_alive[0][4];
    assign bus.dummy_output_0_2 = w_alive[1][0];
    assign bus.dummy_output_1_2 = w_alive[1][1];
    assign bus.dummy_output_2_2 = w_alive[1][2];
    assign bus.dummy_output_3_2 = w_alive[1][3];
    assign bus.dummy_output_4_2 = w_alive[1][4];

endmodule

// File: tb/tb_ndn_fib_lookup.sv
// Testbench for ndn_fib_lookup: directed component streams with
// hand-computed expected match bits, checked through a scoreboard queue
// keyed by the clock edge at which each bit must hold its value.
module tb_ndn_fib_lookup;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;

    ndn_fib_if bus ();

    ndn_fib_lookup dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    // Edge counter: value N after the N-th rising edge.
    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int   due;      // edge after which the bit is sampled
        int   bit_idx;  // (channel-1)*5 + stage
        logic val;
    } exp_t;

    exp_t  exp_q  [$];
    string name_q [$];

    function automatic int b(input int ch, input int stage);
        return (ch - 1) * 5 + stage;
    endfunction

    task automatic expect_bit(input int due, input int bit_idx, input logic val,
                              input string name);
        exp_q.push_back('{due: due, bit_idx: bit_idx, val: val});
        name_q.push_back(name);
    endtask

    task automatic check(input string name, input logic act, input logic want,
                         input bit late);
        total++;
        if (late || act !== want) begin
            bad++;
            $display("FAIL %s: got %b expected %b%s", name, act, want,
                     late ? " (sample slot missed)" : "");
        end
    endtask

    // Monitor: compares outputs on the falling edge, away from updates.
    always @(negedge clk_in) begin
        logic [9:0] obs;
        obs = {bus.dummy_output_4_2, bus.dummy_output_3_2, bus.dummy_output_2_2,
               bus.dummy_output_1_2, bus.dummy_output_0_2,
               bus.dummy_output_4_1, bus.dummy_output_3_1, bus.dummy_output_2_1,
               bus.dummy_output_1_1, bus.dummy_output_0_1};
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].due <= cyc) begin
                check(name_q[i], obs[exp_q[i].bit_idx], exp_q[i].val,
                      exp_q[i].due < cyc);
                exp_q.delete(i);
                name_q.delete(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Drivers
    // ------------------------------------------------------------------
    task automatic step(input logic v1, input logic s1, input logic [31:0] w1,
                        input logic v2, input logic s2, input logic [31:0] w2,
                        output int edge_no);
        @(negedge clk_in);
        bus.comp_valid_1     = v1;
        bus.name_start_1     = s1;
        bus.name_component_1 = w1;
        bus.comp_valid_2     = v2;
        bus.name_start_2     = s2;
        bus.name_component_2 = w2;
        edge_no = cyc + 1;
        @(posedge clk_in);
        #1;
        bus.comp_valid_1 = 1'b0;
        bus.name_start_1 = 1'b0;
        bus.comp_valid_2 = 1'b0;
        bus.name_start_2 = 1'b0;
    endtask

    task automatic send1(input logic s, input logic [31:0] w, output int edge_no);
        step(1'b1, s, w, 1'b0, 1'b0, 32'h0, edge_no);
    endtask

    task automatic tbl_write(input logic [2:0] stage, input logic [5:0] addr,
                             input logic valid, input logic [31:0] tag,
                             input logic [5:0] parent);
        @(negedge clk_in);
        bus.tbl_we     = 1'b1;
        bus.tbl_stage  = stage;
        bus.tbl_addr   = addr;
        bus.tbl_valid  = valid;
        bus.tbl_tag    = tag;
        bus.tbl_parent = parent;
        @(posedge clk_in);
        #1;
        bus.tbl_we = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // One-edge reset; every output must read 0 after that edge.
    task automatic pulse_reset(input string name);
        int e;
        @(negedge clk_in);
        rst_in = 1'b1;
        e = cyc + 1;
        for (int i = 0; i < 10; i++) expect_bit(e, i, 1'b0, name);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
    endtask

    logic [31:0] t6_words [8];

    initial begin
        int e0, e1;
        bus.comp_valid_1 = 1'b0; bus.name_start_1 = 1'b0; bus.name_component_1 = '0;
        bus.comp_valid_2 = 1'b0; bus.name_start_2 = 1'b0; bus.name_component_2 = '0;
        bus.tbl_we = 1'b0; bus.tbl_stage = '0; bus.tbl_addr = '0;
        bus.tbl_valid = 1'b0; bus.tbl_tag = '0; bus.tbl_parent = '0;

        // Reset state
        idle(2);
        pulse_reset("reset_state");
        idle(2);

        // T1: empty FIB, nothing matches
        send1(1'b1, 32'h11, e0); expect_bit(e0 + 1, b(1, 0), 1'b0, "t1_empty_d1");
        send1(1'b0, 32'h22, e0); expect_bit(e0 + 2, b(1, 1), 1'b0, "t1_empty_d2");
        send1(1'b0, 32'h33, e0); expect_bit(e0 + 3, b(1, 2), 1'b0, "t1_empty_d3");
        idle(6);

        // T2: two-level prefix 0x11/0x22
        tbl_write(3'd0, 6'h11, 1'b1, 32'h11, 6'h00);
        tbl_write(3'd1, 6'h33, 1'b1, 32'h22, 6'h11);
        send1(1'b1, 32'h11, e0);
        expect_bit(e0 + 1, b(1, 0), 1'b1, "t2_d1");
        send1(1'b0, 32'h22, e1);
        expect_bit(e1 + 2, b(1, 1), 1'b1, "t2_d2");
        expect_bit(e1 + 3, b(1, 2), 1'b0, "t2_d3_none");
        expect_bit(e1 + 6, b(1, 1), 1'b1, "t2_d2_hold");
        idle(8);

        // T3a: a fresh unmatched name clears depth 2 as its start passes
        send1(1'b1, 32'h55, e0);
        expect_bit(e0 + 1, b(1, 0), 1'b0, "t3_new_d1");
        expect_bit(e0 + 1, b(1, 1), 1'b1, "t3_d2_before_clear");
        expect_bit(e0 + 2, b(1, 1), 1'b0, "t3_d2_cleared");
        idle(5);

        // T3b: second component not in the table
        send1(1'b1, 32'h11, e0);
        expect_bit(e0 + 1, b(1, 0), 1'b1, "t3_d1");
        send1(1'b0, 32'h99, e1);
        expect_bit(e1 + 2, b(1, 1), 1'b0, "t3_d2_tag_miss");
        idle(6);

        // T4: parent pointer mismatch at stage 1
        tbl_write(3'd1, 6'h33, 1'b1, 32'h22, 6'h12);
        send1(1'b1, 32'h11, e0);
        expect_bit(e0 + 1, b(1, 0), 1'b1, "t4_d1");
        send1(1'b0, 32'h22, e1);
        expect_bit(e1 + 2, b(1, 1), 1'b0, "t4_parent_miss");
        idle(6);

        // T5: both channels start together with different names
        tbl_write(3'd1, 6'h33, 1'b1, 32'h22, 6'h11);
        tbl_write(3'd0, 6'h2A, 1'b1, 32'h2A, 6'h00);
        step(1'b1, 1'b1, 32'h11, 1'b1, 1'b1, 32'h2A, e0);
        expect_bit(e0 + 1, b(1, 0), 1'b1, "t5_ch1_d1");
        expect_bit(e0 + 1, b(2, 0), 1'b1, "t5_ch2_d1");
        step(1'b1, 1'b0, 32'h22, 1'b1, 1'b0, 32'h77, e1);
        expect_bit(e1 + 2, b(1, 1), 1'b1, "t5_ch1_d2");
        expect_bit(e1 + 2, b(2, 1), 1'b0, "t5_ch2_d2");
        idle(6);

        // T6: 8-component name, all five levels present
        t6_words = '{32'hCAFE0001, 32'hBEEF0002, 32'h12340003, 32'h00000004,
                     32'hFFFF0005, 32'h00000006, 32'h00000007, 32'h00000008};
        tbl_write(3'd0, 6'h01, 1'b1, t6_words[0], 6'h00);
        tbl_write(3'd1, 6'h03, 1'b1, t6_words[1], 6'h01);
        tbl_write(3'd2, 6'h00, 1'b1, t6_words[2], 6'h03);
        tbl_write(3'd3, 6'h04, 1'b1, t6_words[3], 6'h00);
        tbl_write(3'd4, 6'h01, 1'b1, t6_words[4], 6'h04);
        // A write to a nonexistent stage must not disturb anything.
        tbl_write(3'd5, 6'h01, 1'b0, 32'h0, 6'h00);
        for (int i = 0; i < 8; i++) begin
            send1(i == 0, t6_words[i], e0);
            if (i == 0) expect_bit(e0 + 2, b(1, 1), 1'b0, "t6_d2_cleared");
            if (i < 5) expect_bit(e0 + i + 1, b(1, i), 1'b1,
                                  $sformatf("t6_d%0d", i + 1));
        end
        for (int k = 0; k < 5; k++)
            expect_bit(e0 + 6, b(1, k), 1'b1, $sformatf("t6_tail_d%0d", k + 1));
        expect_bit(e0 + 6, b(2, 0), 1'b1, "t6_ch2_hold");
        idle(8);

        // T7: reset in the middle of a name
        send1(1'b1, t6_words[0], e0);
        expect_bit(e0 + 1, b(1, 0), 1'b1, "t7_d1");
        send1(1'b0, t6_words[1], e1);
        pulse_reset("t7_mid_reset");
        send1(1'b1, t6_words[0], e0);
        expect_bit(e0 + 1, b(1, 0), 1'b0, "t7_table_cleared");
        idle(4);

        // Drain the scoreboard with a bounded wait.
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(posedge clk_in);
        @(negedge clk_in);
        #1;
        while (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s: never sampled (due edge %0d, now %0d)",
                     name_q[0], exp_q[0].due, cyc);
            void'(exp_q.pop_front());
            void'(name_q.pop_front());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ndn_fib_lookup.md
Name: ndn_fib_lookup

Overview:
- Pipelined NDN FIB longest-prefix lookup engine with two independent lookup channels sharing one FIB.
- Each channel accepts a name as a serial stream of 32-bit component words, first component first.
- Stage k checks whether the prefix made of components 0..k exists in the FIB, and drives one match bit per stage per channel.
- Sits between the name parser (component stream) and the forwarding decision logic, which consumes the per-stage match bits.

Parameters:
- WORD_SIZE, 32, width of one name component.
- TREE_HEIGHT, 5, number of lookup stages (maximum matchable prefix depth).
- POINTER_SIZE, 6, table address width; each stage table has 2^POINTER_SIZE entries.
- MAX_NAME_LENGTH, 8, maximum components per name.
- STRIDE_INDEX_SIZE, 3, width of the component-position counter.

Ports:
- clk_in, in, 1, single clock; all logic on the rising edge.
- rst_in, in, 1, synchronous active-high reset.
- name_component_1 / name_component_2, in, WORD_SIZE each, component word for channel 1 / channel 2.
- comp_valid_1 / comp_valid_2, in, 1 each, the component is consumed this cycle.
- name_start_1 / name_start_2, in, 1 each, qualified by valid; marks component 0 of a new name.
- tbl_we, in, 1, FIB table write enable.
- tbl_stage, in, 3, target stage; values >= TREE_HEIGHT are ignored.
- tbl_addr, in, POINTER_SIZE, entry address.
- tbl_valid, in, 1, entry valid bit.
- tbl_tag, in, WORD_SIZE, component word stored in the entry.
- tbl_parent, in, POINTER_SIZE, pointer of the parent entry in stage k-1; ignored for stage 0.
- dummy_output_0_1 .. dummy_output_4_1, out, 1 each, channel 1 match for prefix depth 1..5.
- dummy_output_0_2 .. dummy_output_4_2, out, 1 each, channel 2 match for prefix depth 1..5.

Behaviour:
- Reset: clears every table valid bit, all pipeline valid/context registers and all dummy_output_* to 0.
- Stride counter (per channel):
  - A valid component with name_start gets idx 0.
  - Each later valid component gets idx+1, saturating at MAX_NAME_LENGTH-1.
  - Valid without any prior start is treated as idx 0.
- Pipeline: each valid component enters stage-0 register, then shifts one stage per cycle (TREE_HEIGHT registers, carrying {valid, start, idx, word}).
- Stage k evaluates only a component whose idx == k.
  - Table index: a = word[POINTER_SIZE-1:0] XOR ptr_prev. For stage 0, ptr_prev = 0 and alive_prev = 1.
  - Match: alive_prev && entry[a].valid && entry[a].tag == word && (k==0 || entry[a].parent == ptr_prev).
  - On evaluation, stage context {alive_k <= match, ptr_k <= a} is written; dummy_output_k <= match.
  - ptr_prev and alive_prev come from stage k-1's context register.
- When a component with start=1 passes stage k>0 (and is not evaluated there), alive_k and dummy_output_k clear to 0.
- Outputs hold their value until the next evaluation or clear at that stage.
- Latency: a component with idx k presented at edge t updates dummy_output_k at edge t+k+1.
- Back-to-back components are legal. Stage k+1 always sees stage k's context from component k (at least one cycle old).
- Components with idx >= TREE_HEIGHT pass through without effect.
- A component held valid for two cycles is two components. Producers pulse valid once per component.
- Table writes: take effect at the edge. A same-cycle lookup reads the old contents. Both channels read the same tables (dual read, single write).
- Channels are fully independent; simultaneous starts on both channels are legal.
- Reset mid-name: the pipeline flushes, and the next component must carry name_start.

Decomposition:
- Package ndn_fib_pkg: the parameter defaults, entry struct {valid, tag, parent}, pipeline-slot struct, and the index hash function.
- One sub-module, fib_stage: table storage is separate, it takes entry read data, performs compare and context/output update, and is instantiated TREE_HEIGHT×2 by generate.
- Tables live in the top level as one array per stage.

Test Plan:
- Reset then name {0x11,0x22,0x33} on channel 1 with an empty FIB -> all dummy_output_*_1 stay 0.
- Load stage0[0x11]={1,0x11,-} and stage1[0x22^0x11=0x33]={1,0x22,parent 0x11}; stream 0x11 (start), 0x22 -> dummy_output_0_1 goes 1 at edge t+1, dummy_output_1_1 goes 1 at t+2, dummy_output_2_1 stays 0.
- Same FIB, stream 0x11, 0x99 -> output_0 = 1, output_1 = 0.
  - Then a new name 0x55 (start) -> output_0 = 0 and output_1 cleared as the start slot passes.
- Parent mismatch: stage1 entry with parent 0x12, stream 0x11, 0x22 -> output_1 = 0.
- Channel 1 and channel 2 streams with start on the same cycle, different names -> independent, correct per-channel outputs.
- 8-component name with all 5 levels loaded -> outputs 0..4 all 1. Components 5..7 change nothing.
- Assert reset mid-name -> all outputs 0 on the next edge.
